// File: rtl/aes_out_guard.sv
// aes_out_guard
//   Output guard between the pipelined AES-128 core and the top-level
//   ciphertext port. Each accepted ciphertext word is registered and compared
//   against NUM_PAT programmable watch patterns. Matches are counted with
//   saturation. When the count reaches THRESH, a sticky alarm is latched and
//   every later word is replaced by a fail-safe value until rst.
//
//   Optional feature macro: AES_GUARD_KEY_ECHO_EN
//     defined   : the fail-safe value is the current key, sampled together
//                 with ct (lab bring-up only)
//     undefined : the fail-safe value is all-zero and key is unused
//
// Parameters
//   DATA_W   ciphertext/key/pattern width
//   NUM_PAT  number of pattern slots (>= 1)
//   CNT_W    match counter width
//   THRESH   matches needed to raise the alarm (1 .. 2^CNT_W-1)
//   DEF_PAT  slot 0 pattern after reset (slot 0 is enabled at reset)
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   key         current key (fail-safe source when key echo is enabled)
//   ct_valid    ct holds a valid cipher output this cycle
//   ct          cipher core output
//   pat_we      write pattern slot pat_addr with pat_wdata (addr >= NUM_PAT ignored)
//   pat_clr     disable all slots and clear match_cnt (wins over pat_we)
//   out_valid   one-cycle pulse per accepted ct
//   out         registered guarded output (holds when idle)
//   alarm       sticky alarm
//   match_cnt   saturating match count
//   match_idx   lowest matching slot of the last match
module aes_out_guard #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned NUM_PAT = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned THRESH  = 1,
  parameter logic [DATA_W-1:0] DEF_PAT = 128'h6939b2e898f969350967325782ecc94e,
  localparam int unsigned AW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] key,
  input  logic              ct_valid,
  input  logic [DATA_W-1:0] ct,
  input  logic              pat_we,
  input  logic [AW-1:0]     pat_addr,
  input  logic [DATA_W-1:0] pat_wdata,
  input  logic              pat_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic              alarm,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [AW-1:0]     match_idx
);

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    SEEN  = 2'd1,
    ALARM = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pat_q [NUM_PAT];
  logic [DATA_W-1:0] pat_d [NUM_PAT];
  logic [NUM_PAT-1:0] en_q, en_d;
  logic [NUM_PAT-1:0] wr_sel;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [AW-1:0]     idx_q, idx_d, hit_idx;
  logic              hit, match, thr_hit;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] fail_val;

`ifdef AES_GUARD_KEY_ECHO_EN
  assign fail_val = key;
`else
  logic unused_key;
  assign fail_val   = '0;
  assign unused_key = ^key;
`endif

  // Slot write decode; an address with no matching slot selects nothing.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_PAT; i++) begin
      wr_sel[i] = pat_we && !pat_clr && (pat_addr == AW'(i));
    end
  end

  always_comb begin
    en_d = pat_clr ? '0 : (en_q | wr_sel);
    for (int unsigned i = 0; i < NUM_PAT; i++) begin
      pat_d[i] = wr_sel[i] ? pat_wdata : pat_q[i];
    end
  end

  // Compare against registered (pre-write) slot contents; lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_PAT; i++) begin
      if (!hit && en_q[i] && (pat_q[i] == ct)) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end

  assign match   = ct_valid && hit && !pat_clr;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign thr_hit = (cnt_inc >= CNT_W'(THRESH));

  // Next state, counter and match index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (pat_clr) begin
      cnt_d = '0;
      if (state_q == SEEN) state_d = ARMED;
    end else if (match) begin
      cnt_d = cnt_inc;
      idx_d = hit_idx;
      if (state_q != ALARM) state_d = thr_hit ? ALARM : SEEN;
    end
  end

  // The word that raises the alarm sees alarm=0 here and passes unmasked.
  always_comb begin
    out_valid_d = ct_valid;
    out_d       = out_q;
    if (ct_valid) out_d = (state_q == ALARM) ? fail_val : ct;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARMED;
      cnt_q       <= '0;
      idx_q       <= '0;
      en_q        <= NUM_PAT'(1);
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int unsigned i = 0; i < NUM_PAT; i++) begin
        pat_q[i] <= (i == 0) ? DEF_PAT : '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      for (int unsigned i = 0; i < NUM_PAT; i++) begin
        pat_q[i] <= pat_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign alarm     = (state_q == ALARM);
  assign match_cnt = cnt_q;
  assign match_idx = idx_q;

endmodule

// File: tb/tb_aes_out_guard.sv
// Testbench for aes_out_guard. Two instances: u0 with default parameters
// (THRESH=1) and u1 with NUM_PAT=3, CNT_W=2, THRESH=3. Stimulus pushes the
// expected output word into a per-instance queue; monitors pop and compare
// whenever out_valid is seen. Status outputs are checked directly.
module tb_aes_out_guard;

  localparam logic [127:0] DEF  = 128'h6939b2e898f969350967325782ecc94e;
  localparam logic [127:0] KEYV = {16{8'hAA}};
`ifdef AES_GUARD_KEY_ECHO_EN
  localparam logic [127:0] FAILV = KEYV;
`else
  localparam logic [127:0] FAILV = '0;
`endif
  localparam logic [127:0] XV = 128'hCAFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0 = 1'b0, ctv0 = 1'b0, we0 = 1'b0, clr0 = 1'b0;
  logic [127:0] ct0 = '0, wd0 = '0, out0;
  logic [1:0]   addr0 = '0, idx0;
  logic [7:0]   cnt0;
  logic         ov0, alarm0;

  logic         rst1 = 1'b0, ctv1 = 1'b0, we1 = 1'b0, clr1 = 1'b0;
  logic [127:0] ct1 = '0, wd1 = '0, out1;
  logic [1:0]   addr1 = '0, idx1;
  logic [1:0]   cnt1;
  logic         ov1, alarm1;

  aes_out_guard u0 (
    .clk(clk), .rst(rst0), .key(KEYV), .ct_valid(ctv0), .ct(ct0),
    .pat_we(we0), .pat_addr(addr0), .pat_wdata(wd0), .pat_clr(clr0),
    .out_valid(ov0), .out(out0), .alarm(alarm0), .match_cnt(cnt0),
    .match_idx(idx0)
  );

  aes_out_guard #(.NUM_PAT(3), .CNT_W(2), .THRESH(3)) u1 (
    .clk(clk), .rst(rst1), .key(KEYV), .ct_valid(ctv1), .ct(ct1),
    .pat_we(we1), .pat_addr(addr1), .pat_wdata(wd1), .pat_clr(clr1),
    .out_valid(ov1), .out(out1), .alarm(alarm1), .match_cnt(cnt1),
    .match_idx(idx1)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] q0[$];
  logic [127:0] q1[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [127:0] d, input logic [127:0] e);
    ctv0 = 1'b1; ct0 = d; q0.push_back(e);
    step();
    ctv0 = 1'b0;
  endtask

  task automatic send1(input logic [127:0] d, input logic [127:0] e);
    ctv1 = 1'b1; ct1 = d; q1.push_back(e);
    step();
    ctv1 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ov0) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out0_extra: got %h expected no word", out0);
      end else chk("out0", out0, q0.pop_front());
    end
    if (ov1) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out1_extra: got %h expected no word", out1);
      end else chk("out1", out1, q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1 rst0 = 1'b1; rst1 = 1'b1;
    #11;
    chk("rst_ov0", ov0, 0);       chk("rst_out0", out0, 0);
    chk("rst_alarm0", alarm0, 0); chk("rst_cnt0", cnt0, 0);
    chk("rst_idx0", idx0, 0);
    chk("rst_ov1", ov1, 0);       chk("rst_alarm1", alarm1, 0);
    chk("rst_cnt1", cnt1, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    step();

    // Pass-through stream, back to back
    send0(128'd1, 128'd1);
    send0(128'd2, 128'd2);
    send0(128'd3, 128'd3);
    chk("pass_out0", out0, 3); chk("pass_alarm0", alarm0, 0);
    chk("pass_cnt0", cnt0, 0);

    // THRESH=1: default pattern raises alarm, itself unmasked
    send0(DEF, DEF);
    chk("def_alarm0", alarm0, 1); chk("def_cnt0", cnt0, 1);
    chk("def_idx0", idx0, 0);
    send0(128'd5, FAILV);
    step();
    chk("hold_out0", out0, FAILV); chk("hold_ov0", ov0, 0);

    // Asynchronous reset mid-cycle, with a word in flight that is lost
    ctv0 = 1'b1; ct0 = 128'h77;
    #3 rst0 = 1'b1;
    #1;
    chk("arst_out0", out0, 0); chk("arst_alarm0", alarm0, 0);
    chk("arst_cnt0", cnt0, 0); chk("arst_idx0", idx0, 0);
    step();
    chk("arst_ov0", ov0, 0);
    ctv0 = 1'b0; rst0 = 1'b0;
    step();

    // pat_clr with simultaneous match: clear wins, slot 0 disabled
    clr0 = 1'b1;
    send0(DEF, DEF);
    clr0 = 1'b0;
    chk("clr_cnt0", cnt0, 0); chk("clr_alarm0", alarm0, 0);
    send0(DEF, DEF);
    chk("clr_nomatch_cnt0", cnt0, 0); chk("clr_nomatch_alarm0", alarm0, 0);

    // Write slot 1 while the same value arrives: compared pre-write
    we0 = 1'b1; addr0 = 2'd1; wd0 = XV;
    send0(XV, XV);
    we0 = 1'b0;
    chk("wr_same_cnt0", cnt0, 0);
    send0(XV, XV);
    chk("wr_next_cnt0", cnt0, 1); chk("wr_next_idx0", idx0, 1);
    chk("wr_next_alarm0", alarm0, 1);
    send0(128'd7, FAILV);
    step(); step();

    // u1: THRESH=3, CNT_W=2, NUM_PAT=3 (address 3 is out of range)
    we1 = 1'b1; addr1 = 2'd2; wd1 = 128'h1234;
    step();
    addr1 = 2'd3; wd1 = 128'h9999;
    step();
    we1 = 1'b0;
    send1(128'h1234, 128'h1234);
    chk("t3_cnt1_a", cnt1, 1); chk("t3_idx1", idx1, 2);
    chk("t3_alarm1_a", alarm1, 0);
    send1(128'h0, 128'h0);
    chk("t3_cnt1_gap", cnt1, 1);
    send1(128'h1234, 128'h1234);
    chk("t3_cnt1_b", cnt1, 2); chk("t3_alarm1_b", alarm1, 0);
    send1(128'h0, 128'h0);
    send1(128'h1234, 128'h1234);
    chk("t3_cnt1_c", cnt1, 3); chk("t3_alarm1_c", alarm1, 1);
    send1(128'h9999, FAILV);
    chk("oob_cnt1", cnt1, 3);
    send1(128'h1234, FAILV);
    chk("sat_cnt1_a", cnt1, 3); chk("sat_idx1_a", idx1, 2);
    send1(DEF, FAILV);
    chk("sat_cnt1_b", cnt1, 3); chk("sat_idx1_b", idx1, 0);
    step();

    // Reset during alarm clears everything and re-enables slot 0 only
    #3 rst1 = 1'b1;
    #1;
    chk("arst_out1", out1, 0); chk("arst_ov1", ov1, 0);
    chk("arst_alarm1", alarm1, 0); chk("arst_cnt1", cnt1, 0);
    chk("arst_idx1", idx1, 0);
    step();
    rst1 = 1'b0;
    step();
    send1(DEF, DEF);
    chk("reen_cnt1", cnt1, 1); chk("reen_idx1", idx1, 0);
    chk("reen_alarm1", alarm1, 0);
    send1(128'h1234, 128'h1234);
    chk("slot2_clr_cnt1", cnt1, 1);
    step(); step();

    chk("q0_drained", 128'(q0.size()), 0);
    chk("q1_drained", 128'(q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
